udma_filter_rx_l2_writer: RTL and testbench
===========================================

// Module: udma_filter_rx_l2_writer
// PURPOSE
//  Downstream stage of the uDMA filter RX channel. Consumes the filter's output beat stream
//  (byte address, datasize, data) and buffers it in a small FIFO. Turns each beat into one
//  lane-aligned 32-bit L2 write (word address + byte enables) on a req/gnt port. Decouples
//  filter throughput from L2 arbitration stalls.
// PARAMETERS
//  DATA_WIDTH      32  data width of the filter RX stream and the L2 write bus (fixed at 32)
//  L2_AWIDTH_NOAL  15  width of the byte address carried on the RX stream
//  FIFO_DEPTH      4   number of buffered beats; power of two, >=2
// PORTS
//  clk_i                  in   1                 clock
//  resetn_i               in   1                 asynchronous reset, active-low
//  clear_i                in   1                 synchronous flush of FIFO and counters
//  filter_rx_ch_addr_i    in   L2_AWIDTH_NOAL    byte address of beat
//  filter_rx_ch_datasize_i in  2                 00 byte, 01 half, 10 word, 11 reserved
//  filter_rx_ch_valid_i   in   1                 beat valid
//  filter_rx_ch_data_i    in   DATA_WIDTH        beat data, LSB-justified
//  filter_rx_ch_ready_o   out  1                 beat accepted when valid&ready
//  l2_req_o               out  1                 write request
//  l2_gnt_i               in   1                 grant; completes write on req&gnt
//  l2_addr_o              out  L2_AWIDTH_NOAL-2  word address (byte addr >> 2)
//  l2_be_o                out  4                 byte enables
//  l2_wdata_o             out  DATA_WIDTH        lane-aligned write data
//  idle_o                 out  1                 FIFO empty and no request pending
//  size_err_o             out  1                 1-cycle pulse when a datasize=11 beat is accepted
//  wr_cnt_o               out  32                granted writes (stats, see CONFIGURATION)
//  stall_cnt_o            out  32                cycles with req&!gnt (stats)
// BEHAVIOUR
//  Reset: FIFO empty; ready_o=1; l2_req_o=0; l2_addr_o/be/wdata=0; idle_o=1; size_err_o=0;
//   counters=0.
//  Input: push on valid&ready. ready_o = !full, derived from the registered count.
//   - No push while full, even if a pop happens in the same cycle.
//  Output: l2_req_o = !empty. addr/be/wdata come from the FIFO head (combinational read of
//   the registered storage).
//   - Beat pushed in cycle N appears on l2_req_o in cycle N+1 if the FIFO was empty.
//   - req, addr, be and wdata are held stable until gnt; pop on req&gnt.
//   - Back-to-back grants give one write per cycle.
//  Simultaneous push and pop when not full: count unchanged; order preserved (strict FIFO).
//  Lane mapping, with a = byte addr[1:0]:
//   - byte: be = 1<<a; wdata = data[7:0] << 8a.
//   - half: a[0] ignored; be = a[1] ? 1100 : 0011; wdata = data[15:0] << 16*a[1].
//   - word and reserved(11): be = 1111; wdata = data; a ignored. Size 11 also pulses size_err_o.
//   - Lanes not enabled are driven 0.
//  clear_i has priority over push and pop: FIFO emptied and counters zeroed next cycle.
//   - l2_req_o drops even if a request is ungranted; the bus owner must tolerate the abort.
//   - ready_o stays 1 during clear, but a beat presented in the clear cycle is discarded.
//  Async reset mid-transfer: all state returns to reset values immediately; beats in
//   flight are lost.
//  idle_o = empty (combinational from count).
// CONFIGURATION
//  FILTER_RX_WR_STATS_EN defined:
//   - wr_cnt_o increments on req&gnt; stall_cnt_o increments on req&!gnt.
//   - Both saturate at 32'hFFFFFFFF and are cleared by clear_i.
//  Not defined: no counter flops; wr_cnt_o and stall_cnt_o tied to 0. Ports always present.
// STRUCTURE
//  Package udma_filter_rx_pkg:
//   - datasize_e enum: BYTE, HALF, WORD, RSVD.
//   - rx_beat_t struct: addr, size, data.
//   - function lane_align(rx_beat_t) -> {be, wdata}.
//  Sub-module filter_rx_fifo: generic sync FIFO of rx_beat_t, depth FIFO_DEPTH, with
//   push/pop/clear, full/empty and count.
//  Top: lane alignment, stats counters, size_err_o pulse.
// TESTING
//  1. Byte beats at addrs 400..403, data 8'hA5, gnt=1 -> be 0001,0010,0100,1000;
//     wdata A5<<0/8/16/24; l2_addr 100.
//  2. Half at addr 402, data 16'hBEEF -> be 1100, wdata 32'hBEEF0000;
//     half at addr 401 -> be 0011.
//  3. gnt=0 with FIFO_DEPTH=4, push 5 beats -> ready_o low after 4 accepted;
//     req/addr/data stable; raise gnt -> 4 writes in order, then 5th accepted.
//  4. Continuous valid and gnt, 16 word beats -> one write per cycle, ready_o never drops;
//     wr_cnt_o=16 (stats on).
//  5. clear_i with 3 beats queued and gnt=0 -> next cycle req=0, idle_o=1, counters 0;
//     datasize=11 beat -> be 1111, size_err_o pulses 1 cycle.
//  6. Assert resetn_i low mid-stream -> outputs at reset values immediately;
//     after release, first new beat is written correctly.

Source files
------------

// File: rtl/udma_filter_rx_l2_writer_pkg.sv
// Shared types for the uDMA filter RX L2 writer: beat descriptor, datasize encoding
// and the lane-alignment helper that maps a beat onto a 32-bit L2 write.
package udma_filter_rx_pkg;

    localparam int RX_AWIDTH = 15;
    localparam int RX_DWIDTH = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } datasize_e;

    typedef struct packed {
        logic [RX_AWIDTH-1:0] addr;
        datasize_e            size;
        logic [RX_DWIDTH-1:0] data;
    } rx_beat_t;

    typedef struct packed {
        logic [3:0]           be;
        logic [RX_DWIDTH-1:0] wdata;
    } l2_lane_t;

    // Reserved size is written as a full word, same as WORD.
    function automatic l2_lane_t lane_align(rx_beat_t beat);
        l2_lane_t res;
        res.be    = 4'b0000;
        res.wdata = '0;
        case (beat.size)
            BYTE: begin
                res.be    = 4'b0001 << beat.addr[1:0];
                res.wdata = {24'h000000, beat.data[7:0]} << {beat.addr[1:0], 3'b000};
            end
            HALF: begin
                if (beat.addr[1]) begin
                    res.be    = 4'b1100;
                    res.wdata = {beat.data[15:0], 16'h0000};
                end else begin
                    res.be    = 4'b0011;
                    res.wdata = {16'h0000, beat.data[15:0]};
                end
            end
            default: begin
                res.be    = 4'b1111;
                res.wdata = beat.data;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/udma_filter_rx_l2_writer_if.sv
// Bus interfaces for the L2 writer: the filter RX beat stream and the L2 req/gnt write port.
interface filter_rx_ch_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    logic [AW-1:0] addr;
    logic [1:0]    datasize;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output addr, datasize, valid, data, input ready);
    modport slave  (input addr, datasize, valid, data, output ready);
endinterface

interface l2_wr_if #(
    parameter int AW = 13,
    parameter int DW = 32
);
    logic          req;
    logic          gnt;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;

    modport master (output req, addr, be, wdata, input gnt);
    modport slave  (input req, addr, be, wdata, output gnt);
endinterface

// File: rtl/udma_filter_rx_l2_writer_fifo.sv
// Generic synchronous FIFO with flush; the head entry is read combinationally from storage.
module filter_rx_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0],
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        clear,
    input  logic        push,
    input  T            wr_data,
    input  logic        pop,
    output T            rd_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // A pop in the same cycle does not make room for a push when full.
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/udma_filter_rx_l2_writer.sv
// Buffers filter RX beats and issues one lane-aligned L2 word write per beat.
// Optional write/stall statistics counters are built when FILTER_RX_WR_STATS_EN is defined.
module udma_filter_rx_l2_writer
    import udma_filter_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          clear_i,
    filter_rx_ch_if.slave filter_rx_ch,
    l2_wr_if.master       l2,
    output logic          idle_o,
    output logic          size_err_o,
    output logic [31:0]   wr_cnt_o,
    output logic [31:0]   stall_cnt_o
);

    localparam int CW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    rx_beat_t                  in_beat;
    rx_beat_t                  head;
    l2_lane_t                  lane;
    logic [L2_AWIDTH_NOAL-1:0] head_addr;
    logic [DATA_WIDTH-1:0]     lane_wdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW:0]               fifo_count;
    logic                      accept;
    logic                      size_err_q;

    assign in_beat.addr = filter_rx_ch.addr;
    assign in_beat.size = datasize_e'(filter_rx_ch.datasize);
    assign in_beat.data = filter_rx_ch.data;

    // A beat offered during clear sees ready=1 but is dropped.
    assign filter_rx_ch.ready = !fifo_full;
    assign accept = filter_rx_ch.valid && !fifo_full && !clear_i;

    filter_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (rx_beat_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clear    (clear_i),
        .push     (accept),
        .wr_data  (in_beat),
        .pop      (l2.req && l2.gnt),
        .rd_data  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign lane       = lane_align(head);
    assign head_addr  = head.addr;
    assign lane_wdata = lane.wdata;

    // Outputs are forced to zero while empty so stale storage never leaks onto the bus.
    assign l2.req   = !fifo_empty;
    assign l2.addr  = fifo_empty ? '0 : head_addr[L2_AWIDTH_NOAL-1:2];
    assign l2.be    = fifo_empty ? '0 : lane.be;
    assign l2.wdata = fifo_empty ? '0 : lane_wdata;
    assign idle_o   = (fifo_count == '0);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            size_err_q <= 1'b0;
        end else begin
            size_err_q <= accept && (in_beat.size == RSVD);
        end
    end

    assign size_err_o = size_err_q;

`ifdef FILTER_RX_WR_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating counters; clear wins over any concurrent grant or stall.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else if (clear_i) begin
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (l2.req && l2.gnt && (wr_cnt_q != 32'hFFFF_FFFF))
                wr_cnt_q <= wr_cnt_q + 32'd1;
            if (l2.req && !l2.gnt && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign wr_cnt_o    = wr_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign wr_cnt_o    = 32'd0;
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_udma_filter_rx_l2_writer.sv
// Self-checking bench for udma_filter_rx_l2_writer: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based model of the write stream.
module tb_udma_filter_rx_l2_writer;

    localparam int DEPTH = 4;
`ifdef FILTER_RX_WR_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;
    logic        idle;
    logic        size_err;
    logic [31:0] wr_cnt;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t        mq[$];
    logic        m_size_err = 1'b0;
    logic [31:0] m_wr       = 32'd0;
    logic [31:0] m_stall    = 32'd0;

    filter_rx_ch_if #(.AW(15), .DW(32)) rx_if ();
    l2_wr_if        #(.AW(13), .DW(32)) l2_if ();

    udma_filter_rx_l2_writer #(
        .DATA_WIDTH     (32),
        .L2_AWIDTH_NOAL (15),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .clear_i      (clear),
        .filter_rx_ch (rx_if),
        .l2           (l2_if),
        .idle_o       (idle),
        .size_err_o   (size_err),
        .wr_cnt_o     (wr_cnt),
        .stall_cnt_o  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Expected L2 write computed directly from the lane rules with plain arithmetic.
    function automatic exp_t expectWrite(logic [14:0] a, logic [1:0] sz, logic [31:0] d);
        exp_t e;
        int   lane;
        e.addr = 13'(a / 4);
        lane   = int'(a % 4);
        if (sz == 2'b00) begin
            e.be    = 4'(1 << lane);
            e.wdata = (d & 32'h0000_00FF) << (8 * lane);
        end else if (sz == 2'b01) begin
            lane    = (lane / 2) * 2;
            e.be    = 4'(3 << lane);
            e.wdata = (d & 32'h0000_FFFF) << (8 * lane);
        end else begin
            e.be    = 4'hF;
            e.wdata = d;
        end
        return e;
    endfunction

    task automatic modelReset();
        mq.delete();
        m_size_err = 1'b0;
        m_wr       = 32'd0;
        m_stall    = 32'd0;
    endtask

    task automatic modelStep(input bit v, input logic [14:0] a, input logic [1:0] sz,
                             input logic [31:0] d, input bit g, input bit clr, output bit acc);
        bit busy;
        acc = 1'b0;
        if (clr) begin
            modelReset();
        end else begin
            busy = (mq.size() != 0);
            acc  = v && (mq.size() < DEPTH);
            if (busy && g && m_wr != 32'hFFFF_FFFF) m_wr++;
            if (busy && !g && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (busy && g) void'(mq.pop_front());
            if (acc) mq.push_back(expectWrite(a, sz, d));
            m_size_err = acc && (sz == 2'b11);
        end
    endtask

    task automatic checkAll(input string ph);
        exp_t h;
        bit   ne;
        ne = (mq.size() != 0);
        h  = '0;
        if (ne) h = mq[0];
        checkOutput({ph, ".req"},      l2_if.req,   32'(ne));
        checkOutput({ph, ".ready"},    rx_if.ready, 32'(mq.size() < DEPTH));
        checkOutput({ph, ".idle"},     idle,        32'(!ne));
        checkOutput({ph, ".addr"},     l2_if.addr,  h.addr);
        checkOutput({ph, ".be"},       l2_if.be,    h.be);
        checkOutput({ph, ".wdata"},    l2_if.wdata, h.wdata);
        checkOutput({ph, ".size_err"}, size_err,    m_size_err);
        checkOutput({ph, ".wr_cnt"},   wr_cnt,      STATS_EN ? m_wr : 32'd0);
        checkOutput({ph, ".stall"},    stall_cnt,   STATS_EN ? m_stall : 32'd0);
    endtask

    // Called just after a falling edge: drive one cycle, step the model, check after the edge.
    task automatic applyStimulus(input string ph, input bit v, input logic [14:0] a,
                                 input logic [1:0] sz, input logic [31:0] d,
                                 input bit g, input bit clr, output bit acc);
        rx_if.valid    = v;
        rx_if.addr     = a;
        rx_if.datasize = sz;
        rx_if.data     = d;
        l2_if.gnt      = g;
        clear          = clr;
        modelStep(v, a, sz, d, g, clr, acc);
        @(negedge clk);
        checkAll(ph);
    endtask

    task automatic idleCycles(input int n, input bit g);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus("idle", 1'b0, 15'd0, 2'b00, 32'd0, g, 1'b0, acc);
    endtask

    initial begin
        bit          acc;
        bit          have;
        logic [14:0] ra;
        logic [1:0]  rs;
        logic [31:0] rd;
        bit          rg;
        bit          rc;

        resetn         = 1'b0;
        clear          = 1'b0;
        rx_if.valid    = 1'b0;
        rx_if.addr     = '0;
        rx_if.datasize = '0;
        rx_if.data     = '0;
        l2_if.gnt      = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll("reset");
        resetn = 1'b1;

        $display("[TB] byte lanes at 400..403");
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t1", 1'b1, 15'(400 + i), 2'b00, 32'hFFFF_FFA5, 1'b1, 1'b0, acc);
            checkOutput("t1_be",    l2_if.be,    32'(1 << i));
            checkOutput("t1_wdata", l2_if.wdata, 32'hA5 << (8 * i));
            checkOutput("t1_addr",  l2_if.addr,  32'd100);
        end
        idleCycles(2, 1'b1);

        $display("[TB] half lanes");
        applyStimulus("t2", 1'b1, 15'd402, 2'b01, 32'h1234_BEEF, 1'b1, 1'b0, acc);
        checkOutput("t2_be_hi",    l2_if.be,    32'b1100);
        checkOutput("t2_wdata_hi", l2_if.wdata, 32'hBEEF_0000);
        applyStimulus("t2", 1'b1, 15'd401, 2'b01, 32'h1234_BEEF, 1'b1, 1'b0, acc);
        checkOutput("t2_be_lo",    l2_if.be,    32'b0011);
        checkOutput("t2_wdata_lo", l2_if.wdata, 32'h0000_BEEF);
        idleCycles(2, 1'b1);

        $display("[TB] backpressure with gnt low");
        for (int i = 0; i < 4; i++)
            applyStimulus("t3", 1'b1, 15'(16 * i + 4), 2'b10, 32'(32'hC0DE_0000 + i), 1'b0, 1'b0, acc);
        checkOutput("t3_ready_full", rx_if.ready, 32'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus("t3hold", 1'b1, 15'd200, 2'b10, 32'hC0DE_0004, 1'b0, 1'b0, acc);
        checkOutput("t3_head_addr", l2_if.addr,  32'd1);
        checkOutput("t3_head_data", l2_if.wdata, 32'hC0DE_0000);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++)
            applyStimulus("t3drain", 1'b1, 15'd200, 2'b10, 32'hC0DE_0004, 1'b1, 1'b0, acc);
        checkOutput("t3_fifth_accepted", 32'(acc), 32'd1);
        idleCycles(5, 1'b1);

        $display("[TB] streaming 16 words");
        applyStimulus("t4clr", 1'b0, 15'd0, 2'b00, 32'd0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t4_ready", rx_if.ready, 32'd1);
            applyStimulus("t4", 1'b1, 15'(1000 + 4 * i), 2'b10, $urandom, 1'b1, 1'b0, acc);
        end
        idleCycles(1, 1'b1);
        checkOutput("t4_wr_cnt", wr_cnt, STATS_EN ? 32'd16 : 32'd0);

        $display("[TB] clear with pending beats, reserved size");
        for (int i = 0; i < 3; i++)
            applyStimulus("t5", 1'b1, 15'(8 * i), 2'b00, 32'(i + 1), 1'b0, 1'b0, acc);
        applyStimulus("t5clr", 1'b1, 15'd44, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
        checkOutput("t5_req",   l2_if.req, 32'd0);
        checkOutput("t5_idle",  idle,      32'd1);
        checkOutput("t5_stall", stall_cnt, 32'd0);
        applyStimulus("t5rsvd", 1'b1, 15'h0123, 2'b11, 32'h1234_5678, 1'b0, 1'b0, acc);
        checkOutput("t5_rsvd_be",    l2_if.be,    32'hF);
        checkOutput("t5_rsvd_wdata", l2_if.wdata, 32'h1234_5678);
        checkOutput("t5_size_err",   size_err,    32'd1);
        applyStimulus("t5", 1'b0, 15'd0, 2'b00, 32'd0, 1'b1, 1'b0, acc);
        checkOutput("t5_size_err_pulse", size_err, 32'd0);

        $display("[TB] async reset mid-stream");
        for (int i = 0; i < 3; i++)
            applyStimulus("t6", 1'b1, 15'(100 + i), 2'b00, 32'h5A, 1'b0, 1'b0, acc);
        #2 resetn = 1'b0;
        rx_if.valid = 1'b0;
        modelReset();
        #1;
        checkAll("t6rst");
        checkOutput("t6_req_now", l2_if.req, 32'd0);
        @(negedge clk);
        checkAll("t6hold");
        resetn = 1'b1;
        applyStimulus("t6new", 1'b1, 15'd402, 2'b00, 32'h77, 1'b0, 1'b0, acc);
        checkOutput("t6_new_be",    l2_if.be,    32'b0100);
        checkOutput("t6_new_wdata", l2_if.wdata, 32'h0077_0000);
        idleCycles(2, 1'b1);

        $display("[TB] random traffic");
        have = 1'b0;
        ra = '0;
        rs = '0;
        rd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!have && $urandom_range(99) < 70) begin
                have = 1'b1;
                ra   = 15'($urandom);
                rs   = 2'($urandom);
                rd   = $urandom;
            end
            rg = ($urandom_range(99) < 55);
            rc = ($urandom_range(99) < 3);
            applyStimulus("rand", have, ra, rs, rd, rg, rc, acc);
            if (acc || rc) have = 1'b0;
        end
        idleCycles(6, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
